cnt_operand_stage: RTL and testbench
====================================

# cnt_operand_stage

Registered operand stage directly upstream of the bit-manipulation count unit (clz/ctz/cpop and their word forms). It captures the count operand, immediate selector bits and the word-operation flag behind a valid/ready handshake, and precomputes the bit-reversed operand so the count unit only sees flop outputs. A two-entry skid buffer provides full throughput with a registered input-ready path.

## Interface
Parameters:
- WIDTH, 32, datapath width; legal values 32 or 64.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- Flush  input  1  synchronous flush; discards all held entries.
- InValid  input  1  upstream offers an operand.
- InReady  output  1  stage can accept; a transfer occurs when InValid && InReady.
- InA  input  WIDTH  operand.
- InB  input  5  low 5 bits of the immediate/funct field (B[0] selects trailing count, B[1] selects popcount).
- InW64  input  1  word operation; only meaningful when WIDTH==64.
- OutValid  output  1  held entry presented to the count unit.
- OutReady  input  1  count unit consumes; a transfer occurs when OutValid && OutReady.
- OutA  output  WIDTH  registered operand.
- OutRevA  output  WIDTH  registered bit-reversal of OutA: OutRevA[i] = OutA[WIDTH-1-i].
- OutB  output  5  registered InB.
- OutW64  output  1  registered InW64; constant 0 when WIDTH==32.
- Occupancy  output  2  number of held entries, 0..2.

## Operation
- Two entries: main (drives Out*) and skid. States: EMPTY (0), ONE (main valid), FULL (main + skid valid).
- Bit reversal is computed on the InA side and stored with the entry, never recomputed from the output register.
- InReady = (state != FULL). OutValid = (state != EMPTY). Occupancy encodes state: 0/1/2.
- Transitions, given in = InValid&&InReady and out = OutValid&&OutReady:
  - EMPTY: in -> ONE (main <- input).
  - ONE: in && !out -> FULL (skid <- input); in && out -> ONE (main <- input); !in && out -> EMPTY; else hold.
  - FULL: out -> ONE (main <- skid); InReady=0 so no input is taken; else hold.
- Ordering is strictly FIFO; an entry is presented exactly once.
- Flush: next state EMPTY regardless of in/out; an input offered in the same cycle is dropped; Flush and a consuming OutReady in the same cycle count as consumed (downstream takes the presented entry; nothing else changes).
- WIDTH==32: InW64 ignored, OutW64 tied 0.
- Data registers are not cleared on consumption or flush; only OutValid qualifies them.

## Timing
- Latency: input accepted at edge N is on Out* from after edge N (visible cycle N+1) when the stage was EMPTY or main drained in cycle N.
- Throughput: one transfer per cycle sustained with OutReady held high.
- InReady is a pure function of state flops; no combinational path from OutReady or InValid to InReady.
- OutValid, Out*, Occupancy are flop outputs.
- Reset (synchronous, dominates Flush and handshakes): state EMPTY, OutValid=0, InReady=1 after the edge, Occupancy=0, OutA=OutRevA=0, OutB=0, OutW64=0, skid data 0. Handshakes during a reset cycle have no effect.
- Reset or Flush asserted while FULL drops both entries; no partial drain.

## Structure
- No shared-package typedefs required; state encoding is the 2-bit Occupancy value, local to the module.
- Storage uses the codebase's existing enabled reset flop (flopenr) for main and skid data; no new shared constants.
- One natural sub-module: bitreverse #(WIDTH), a purely combinational reversal, reusable by other bmu stages.

## Test plan
- WIDTH=64, InA=64'h0000_0000_0000_0001, InB=5'b00001, InW64=0, OutReady=1 -> next cycle OutValid=1, OutRevA=64'h8000_0000_0000_0000, OutB=1, Occupancy=1.
- Backpressure: OutReady=0, three back-to-back inputs A=1,2,3 -> first two accepted, InReady=0 on third, Occupancy=2; raise OutReady -> outputs 1,2,3 in order, one per cycle, third accepted the cycle after first drains.
- Streaming: InValid=OutReady=1 for 16 cycles with A=0..15 -> 16 outputs, no bubbles after the first, InReady never drops.
- Flush while FULL with InValid=1, A=7 -> next cycle OutValid=0, Occupancy=0, A=7 never appears on output.
- Reset mid-stream (FULL) -> next cycle OutValid=0, OutA=0, OutRevA=0, InReady=1; first post-reset input appears unchanged.
- WIDTH=32, InA=32'h0000_00F0, InW64=1 -> OutRevA=32'h0F00_0000, OutW64=0.

Source files
------------

// File: rtl/cnt_operand_stage_pkg.sv
// Shared types and constants for the bmu count-unit operand stage.
package cnt_operand_stage_pkg;

    // Width of the immediate/funct selector field carried with the operand.
    localparam int unsigned B_W = 5;

    // Selector bit positions within the B field.
    localparam int unsigned B_TRAILING_BIT = 0;
    localparam int unsigned B_POPCOUNT_BIT = 1;

    // Occupancy-encoded stage state; the encoding is the Occupancy output value.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage : cnt_operand_stage_pkg

// File: rtl/cnt_operand_stage_bitreverse.sv
// Purely combinational bit reversal: y[i] = a[WIDTH-1-i].
module bitreverse #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    // Mirror each bit position.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_rev
        assign y[i] = a[WIDTH-1-i];
    end

endmodule : bitreverse

// File: rtl/flopenr.sv
// Enabled flop with synchronous active-high reset to zero.
module flopenr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset dominates enable; q holds when en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : flopenr

// File: rtl/cnt_operand_stage.sv
// Registered operand stage in front of the clz/ctz/cpop count unit.
// Two-entry skid buffer (main drives Out*, skid absorbs one extra beat) so
// InReady comes straight from a flop while full throughput is kept.
module cnt_operand_stage
    import cnt_operand_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InA,
    input  logic [B_W-1:0]   InB,
    input  logic             InW64,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutRevA,
    output logic [B_W-1:0]   OutB,
    output logic             OutW64,
    output logic [1:0]       Occupancy
);

    // Entry payload layout: {a, rev_a, b, w64}.
    localparam int unsigned PW       = 2 * WIDTH + B_W + 1;
    localparam int unsigned A_LSB    = WIDTH + B_W + 1;
    localparam int unsigned REV_LSB  = B_W + 1;
    localparam int unsigned B_LSB    = 1;

    state_t            state_q;
    state_t            state_d;
    logic              in_ready_q;
    logic              out_valid_q;

    logic              in_xfer_c;
    logic              out_xfer_c;
    logic              main_en_c;
    logic              skid_en_c;
    logic              main_sel_skid_c;

    logic [WIDTH-1:0]  rev_in_c;
    logic              w64_in_c;
    logic [PW-1:0]     in_payload_c;
    logic [PW-1:0]     main_d_c;
    logic [PW-1:0]     main_q;
    logic [PW-1:0]     skid_q;

    // Reverse on the input side so the stored entry already holds rev(a).
    bitreverse #(
        .WIDTH (WIDTH)
    ) u_bitreverse (
        .a (InA),
        .y (rev_in_c)
    );

    // Word-operation flag only exists for the 64-bit datapath.
    assign w64_in_c     = (WIDTH == 64) ? InW64 : 1'b0;
    assign in_payload_c = {InA, rev_in_c, InB, w64_in_c};

    // Handshake qualifiers use registered ready/valid only.
    assign in_xfer_c  = InValid && in_ready_q;
    assign out_xfer_c = out_valid_q && OutReady;

    // Main refills from skid when draining FULL, otherwise from the input.
    assign main_d_c = main_sel_skid_c ? skid_q : in_payload_c;

    // Next-state and entry load enables; flush drops everything incl. the offered input.
    always_comb begin
        state_d         = state_q;
        main_en_c       = 1'b0;
        skid_en_c       = 1'b0;
        main_sel_skid_c = 1'b0;
        if (Flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer_c) begin
                        state_d   = ST_ONE;
                        main_en_c = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer_c && !out_xfer_c) begin
                        state_d   = ST_FULL;
                        skid_en_c = 1'b1;
                    end else if (in_xfer_c && out_xfer_c) begin
                        state_d   = ST_ONE;
                        main_en_c = 1'b1;
                    end else if (out_xfer_c) begin
                        state_d   = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer_c) begin
                        state_d         = ST_ONE;
                        main_en_c       = 1'b1;
                        main_sel_skid_c = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State register with ready/valid decoded from the next state into flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    // Main entry storage; drives the count unit.
    flopenr #(
        .WIDTH (PW)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en_c),
        .d     (main_d_c),
        .q     (main_q)
    );

    // Skid entry storage; only written from the input.
    flopenr #(
        .WIDTH (PW)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en_c),
        .d     (in_payload_c),
        .q     (skid_q)
    );

    assign InReady   = in_ready_q;
    assign OutValid  = out_valid_q;
    assign Occupancy = state_q;
    assign OutA      = main_q[A_LSB   +: WIDTH];
    assign OutRevA   = main_q[REV_LSB +: WIDTH];
    assign OutB      = main_q[B_LSB   +: B_W];
    assign OutW64    = main_q[0];

endmodule : cnt_operand_stage

// File: tb/tb_cnt_operand_stage.sv
// Directed bench for cnt_operand_stage at WIDTH=64 and WIDTH=32.
module tb_cnt_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        Flush;

    logic        InValid, InReady, InW64, OutValid, OutReady, OutW64;
    logic [63:0] InA, OutA, OutRevA;
    logic [4:0]  InB, OutB;
    logic [1:0]  Occupancy;

    logic        InValid32, InReady32, InW64_32, OutValid32, OutReady32, OutW64_32;
    logic [31:0] InA32, OutA32, OutRevA32;
    logic [4:0]  InB32, OutB32;
    logic [1:0]  Occupancy32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cnt_operand_stage #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .Flush(Flush),
        .InValid(InValid), .InReady(InReady), .InA(InA), .InB(InB), .InW64(InW64),
        .OutValid(OutValid), .OutReady(OutReady), .OutA(OutA), .OutRevA(OutRevA),
        .OutB(OutB), .OutW64(OutW64), .Occupancy(Occupancy)
    );

    cnt_operand_stage #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .Flush(Flush),
        .InValid(InValid32), .InReady(InReady32), .InA(InA32), .InB(InB32), .InW64(InW64_32),
        .OutValid(OutValid32), .OutReady(OutReady32), .OutA(OutA32), .OutRevA(OutRevA32),
        .OutB(OutB32), .OutW64(OutW64_32), .Occupancy(Occupancy32)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; Flush = 1'b0;
        InValid = 1'b0; InA = '0; InB = '0; InW64 = 1'b0; OutReady = 1'b0;
        InValid32 = 1'b0; InA32 = '0; InB32 = '0; InW64_32 = 1'b0; OutReady32 = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_outvalid", 64'(OutValid), 64'd0);
        check("rst_inready",  64'(InReady),  64'd1);
        check("rst_occ",      64'(Occupancy), 64'd0);
        check("rst_outa",     OutA, 64'd0);
        check("rst_outreva",  OutRevA, 64'd0);
        check("rst_outb",     64'(OutB), 64'd0);
        check("rst_outw64",   64'(OutW64), 64'd0);

        // Single operand, first-beat latency and reversal
        InValid = 1'b1; InA = 64'h0000_0000_0000_0001; InB = 5'b00001; InW64 = 1'b0; OutReady = 1'b1;
        tick();
        InValid = 1'b0;
        check("t1_outvalid", 64'(OutValid), 64'd1);
        check("t1_outa",     OutA, 64'h0000_0000_0000_0001);
        check("t1_outreva",  OutRevA, 64'h8000_0000_0000_0000);
        check("t1_outb",     64'(OutB), 64'd1);
        check("t1_occ",      64'(Occupancy), 64'd1);
        tick();
        check("t1_drained",  64'(Occupancy), 64'd0);

        // Backpressure: fill both entries, third beat stalled
        OutReady = 1'b0; InB = 5'd0;
        InValid = 1'b1; InA = 64'd1; tick();
        InA = 64'd2; tick();
        InA = 64'd3;
        check("bp_inready_full", 64'(InReady), 64'd0);
        check("bp_occ_full",     64'(Occupancy), 64'd2);
        check("bp_outa_first",   OutA, 64'd1);
        tick();
        check("bp_hold_occ",     64'(Occupancy), 64'd2);
        check("bp_hold_outa",    OutA, 64'd1);
        OutReady = 1'b1;
        tick();
        check("bp_second_outa",  OutA, 64'd2);
        check("bp_second_reva",  OutRevA, 64'h4000_0000_0000_0000);
        check("bp_second_occ",   64'(Occupancy), 64'd1);
        check("bp_inready_back", 64'(InReady), 64'd1);
        tick();
        InValid = 1'b0;
        check("bp_third_outa",   OutA, 64'd3);
        check("bp_third_valid",  64'(OutValid), 64'd1);
        tick();
        check("bp_empty_valid",  64'(OutValid), 64'd0);
        check("bp_empty_occ",    64'(Occupancy), 64'd0);

        // Streaming at one beat per cycle
        InValid = 1'b1; OutReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            InA = 64'(i); InB = 5'(i);
            tick();
            check("st_outa",    OutA, 64'(i));
            check("st_outb",    64'(OutB), 64'(i));
            check("st_valid",   64'(OutValid), 64'd1);
            check("st_inready", 64'(InReady), 64'd1);
        end
        InValid = 1'b0; InB = 5'd0;
        tick();
        check("st_end_valid", 64'(OutValid), 64'd0);

        // Flush while FULL with an input offered
        OutReady = 1'b0; InValid = 1'b1;
        InA = 64'd5; tick();
        InA = 64'd6; tick();
        check("fl_pre_occ", 64'(Occupancy), 64'd2);
        InA = 64'd7; Flush = 1'b1;
        tick();
        Flush = 1'b0; InValid = 1'b0;
        check("fl_valid",   64'(OutValid), 64'd0);
        check("fl_occ",     64'(Occupancy), 64'd0);
        check("fl_inready", 64'(InReady), 64'd1);
        check("fl_data_kept", OutA, 64'd5);
        OutReady = 1'b1;
        tick();
        check("fl_no_seven_valid", 64'(OutValid), 64'd0);
        tick();
        check("fl_no_seven_occ",   64'(Occupancy), 64'd0);

        // Reset while FULL, then first post-reset beat
        OutReady = 1'b0; InValid = 1'b1;
        InA = 64'd8; tick();
        InA = 64'd9; tick();
        check("rs_pre_occ", 64'(Occupancy), 64'd2);
        reset = 1'b1; InA = 64'd10; OutReady = 1'b1;
        tick();
        reset = 1'b0; InValid = 1'b0;
        check("rs_valid",   64'(OutValid), 64'd0);
        check("rs_outa",    OutA, 64'd0);
        check("rs_outreva", OutRevA, 64'd0);
        check("rs_inready", 64'(InReady), 64'd1);
        check("rs_occ",     64'(Occupancy), 64'd0);
        InValid = 1'b1; InA = 64'h0123_4567_89AB_CDEF; InB = 5'h1F; InW64 = 1'b1;
        tick();
        InValid = 1'b0;
        check("rs_post_outa",  OutA, 64'h0123_4567_89AB_CDEF);
        check("rs_post_reva",  OutRevA, 64'hF7B3_D591_E6A2_C480);
        check("rs_post_outb",  64'(OutB), 64'h1F);
        check("rs_post_w64",   64'(OutW64), 64'd1);
        check("rs_post_valid", 64'(OutValid), 64'd1);

        // 32-bit instance: W64 ignored
        InValid32 = 1'b1; InA32 = 32'h0000_00F0; InB32 = 5'b00010; InW64_32 = 1'b1; OutReady32 = 1'b1;
        tick();
        InValid32 = 1'b0;
        check("w32_valid",  64'(OutValid32), 64'd1);
        check("w32_outa",   64'(OutA32), 64'h0000_00F0);
        check("w32_outreva", 64'(OutRevA32), 64'h0F00_0000);
        check("w32_outw64", 64'(OutW64_32), 64'd0);
        check("w32_outb",   64'(OutB32), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cnt_operand_stage
